// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and op-class helpers used by the decoder and the MDU.
// Optional feature macro: MDU_MADD_EN (enables op 9, madd).
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9
   } mduOp_t;

   localparam int unsigned MULT_CYC_DEF = 5;
   localparam int unsigned DIV_CYC_DEF  = 10;

   // True for ops that occupy the unit for several cycles.
   function automatic logic isMultiCycle(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: isMultiCycle = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD:                            isMultiCycle = 1'b1;
`endif
         default:                            isMultiCycle = 1'b0;
      endcase
   endfunction

   // True for ops that use the multiply latency.
   function automatic logic isMultFamily(input logic [3:0] op);
      isMultFamily = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: mult/multu/div/divu (and madd when
// MDU_MADD_EN is defined) computed from the latched operands.
// resValid is low for divide by zero and for non-arithmetic ops.
module mdu_arith
   import mdu_pkg::*;
(
   input  mduOp_t      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MDU_MADD_EN
   input  logic [31:0] hiIn,
   input  logic [31:0] loIn,
`endif
   output logic [31:0] hiRes,
   output logic [31:0] loRes,
   output logic        resValid
);

   logic [63:0] prodS;
   logic [63:0] prodU;
   logic [31:0] divisor;
   logic [31:0] quotS;
   logic [31:0] remS;
   logic [31:0] quotU;
   logic [31:0] remU;
`ifdef MDU_MADD_EN
   logic [63:0] accSum;
`endif

   // Products, quotients and remainders; divisor forced to 1 on zero so the
   // dividers never see a zero operand (the result is discarded anyway).
   always_comb begin
      prodS   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prodU   = {32'd0, a} * {32'd0, b};
      divisor = (b == '0) ? 32'd1 : b;
      quotS   = $signed(a) / $signed(divisor);
      remS    = $signed(a) % $signed(divisor);
      quotU   = a / divisor;
      remU    = a % divisor;
`ifdef MDU_MADD_EN
      accSum  = {hiIn, loIn} + prodS;
`endif
   end

   // Result select by latched op.
   always_comb begin
      hiRes    = '0;
      loRes    = '0;
      resValid = 1'b0;
      case (op)
         OP_MULT: begin
            {hiRes, loRes} = prodS;
            resValid       = 1'b1;
         end
         OP_MULTU: begin
            {hiRes, loRes} = prodU;
            resValid       = 1'b1;
         end
         OP_DIV: begin
            hiRes    = remS;
            loRes    = quotS;
            resValid = (b != '0);
         end
         OP_DIVU: begin
            hiRes    = remU;
            loRes    = quotU;
            resValid = (b != '0);
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            {hiRes, loRes} = accSum;
            resValid       = 1'b1;
         end
`endif
         default: begin
            hiRes    = '0;
            loRes    = '0;
            resValid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multicycle multiply/divide sequencer: accepts ops from E, runs a busy
// counter, owns the architectural HI/LO registers and raises the D-stage
// stall. Optional feature macro: MDU_MADD_EN (madd, op 9).
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEF,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOpE,
   input  logic [3:0]  MDUOpD,
   input  logic [31:0] RsE,
   input  logic [31:0] RtE,
   output logic        Start,
   output logic        Busy,
   output logic        StallMDU,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOutE
);

   localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countNext;
   mduOp_t           opQ;
   logic [31:0]      rsQ;
   logic [31:0]      rtQ;
   logic [31:0]      hiRes;
   logic [31:0]      loRes;
   logic             resValid;
   logic             wbEn;

   mdu_arith uArith (
      .op       (opQ),
      .a        (rsQ),
      .b        (rtQ),
`ifdef MDU_MADD_EN
      .hiIn     (HI),
      .loIn     (LO),
`endif
      .hiRes    (hiRes),
      .loRes    (loRes),
      .resValid (resValid)
   );

   // Outputs: accept, busy, stall and mfhi/mflo read mux (no bypass).
   always_comb begin
      Busy     = (count != '0);
      Start    = isMultiCycle(MDUOpE) && (count == '0);
      StallMDU = (Start || Busy) && (MDUOpD != 4'd0);
      case (MDUOpE)
         OP_MFHI: MDUOutE = HI;
         OP_MFLO: MDUOutE = LO;
         default: MDUOutE = '0;
      endcase
      wbEn     = (count == CNT_W'(1)) && resValid;
   end

   // Next counter value: load on accept, count down while busy.
   always_comb begin
      countNext = count;
      if (Start)
         countNext = isMultFamily(MDUOpE) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
      else if (Busy)
         countNext = count - CNT_W'(1);
   end

   // Counter and latched operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         opQ   <= OP_NONE;
         rsQ   <= '0;
         rtQ   <= '0;
      end else begin
         count <= countNext;
         if (Start) begin
            opQ <= mduOp_t'(MDUOpE);
            rsQ <= RsE;
            rtQ <= RtE;
         end
      end
   end

   // HI/LO: result writeback on the final busy edge, mthi/mtlo when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI <= '0;
         LO <= '0;
      end else if (wbEn) begin
         HI <= hiRes;
         LO <= loRes;
      end else if (!Busy) begin
         if (MDUOpE == OP_MTHI) HI <= RsE;
         if (MDUOpE == OP_MTLO) LO <= RsE;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a behavioural model tracks HI/LO
// and the remaining busy time; a negedge process compares every cycle.
module tb_mdu_sequencer;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  opE, opD;
   logic [31:0] rs, rt;
   logic        Start, Busy, StallMDU;
   logic [31:0] HI, LO, MDUOutE;

   int checks   = 0;
   int failures = 0;

   // Model state
   logic [31:0] mHi, mLo, pa, pb;
   logic [3:0]  pOp;
   int          mCnt;
   bit          chkEn = 0;

   mdu_sequencer #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
      .clk      (clk),
      .reset    (reset),
      .MDUOpE   (opE),
      .MDUOpD   (opD),
      .RsE      (rs),
      .RtE      (rt),
      .Start    (Start),
      .Busy     (Busy),
      .StallMDU (StallMDU),
      .HI       (HI),
      .LO       (LO),
      .MDUOutE  (MDUOutE)
   );

   always #5 clk = ~clk;

   function automatic bit mMulti(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
      if (op == 4'd9) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mHi = '0; mLo = '0; pa = '0; pb = '0; pOp = '0; mCnt = 0;
   endtask

   // Completion of the pending op, from plain arithmetic.
   task automatic modelFinish();
      longint      sp;
      logic [63:0] up, acc;
      int          qa, qb;
      sp = longint'(signed'(pa)) * longint'(signed'(pb));
      up = 64'(pa) * 64'(pb);
      qa = signed'(pa);
      qb = signed'(pb);
      case (pOp)
         4'd1: begin mHi = sp[63:32]; mLo = sp[31:0]; end
         4'd2: begin mHi = up[63:32]; mLo = up[31:0]; end
         4'd3: if (pb != 0) begin mLo = qa / qb; mHi = qa % qb; end
         4'd4: if (pb != 0) begin mLo = pa / pb; mHi = pa % pb; end
         4'd9: begin acc = {mHi, mLo} + 64'(sp); mHi = acc[63:32]; mLo = acc[31:0]; end
         default: ;
      endcase
   endtask

   // Model update at a rising edge with the current inputs.
   task automatic modelEdge();
      bit wasBusy;
      if (reset) begin
         modelReset();
         return;
      end
      wasBusy = (mCnt != 0);
      if (mMulti(opE) && !wasBusy) begin
         pOp = opE; pa = rs; pb = rt;
         mCnt = (opE == 4'd3 || opE == 4'd4) ? DC : MC;
      end else if (wasBusy) begin
         mCnt--;
         if (mCnt == 0) modelFinish();
      end
      if (!wasBusy && opE == 4'd7) mHi = rs;
      if (!wasBusy && opE == 4'd8) mLo = rs;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin : cmp
      logic        eStart, eBusy, eStall;
      logic [31:0] eOut;
      if (chkEn) begin
         eStart = mMulti(opE) && (mCnt == 0);
         eBusy  = (mCnt != 0);
         eStall = (eStart || eBusy) && (opD != 4'd0);
         eOut   = (opE == 4'd5) ? mHi : (opE == 4'd6) ? mLo : 32'd0;
         chk("Start",    64'(Start),    64'(eStart));
         chk("Busy",     64'(Busy),     64'(eBusy));
         chk("StallMDU", 64'(StallMDU), 64'(eStall));
         chk("HI",       64'(HI),       64'(mHi));
         chk("LO",       64'(LO),       64'(mLo));
         chk("MDUOutE",  64'(MDUOutE),  64'(eOut));
      end
   end

   task automatic step(input logic [3:0] e, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] b);
      opE = e; opD = d; rs = a; rt = b;
      @(negedge clk);
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Issue op and count the busy cycles that follow (bounded).
   task automatic runOp(input logic [3:0] e, input logic [31:0] a,
                        input logic [31:0] b, output int n);
      step(e, 4'd0, a, b);
      n = 0;
      while (Busy && n < 40) begin
         step(4'd0, 4'd0, 0, 0);
         n++;
      end
   endtask

   initial begin
      int n;
      opE = 0; opD = 0; rs = 0; rt = 0;
      reset = 1'b1;
      modelReset();
      @(posedge clk); #1;
      chkEn = 1;
      chk("rst_HI", 64'(HI), 64'h0);
      chk("rst_LO", 64'(LO), 64'h0);
      chk("rst_Busy", 64'(Busy), 64'h0);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      step(0, 0, 0, 0);

      // mult -2 * 3
      runOp(4'd1, 32'hFFFF_FFFE, 32'd3, n);
      chk("mult_busy_cycles", 64'(n), 64'd5);
      chk("mult_HI", 64'(HI), 64'hFFFF_FFFF);
      chk("mult_LO", 64'(LO), 64'hFFFF_FFFA);

      // multu with stall at accept; mthi and mult ignored while busy
      step(4'd2, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step(4'd7, 4'd0, 32'h0000_DEAD, 0);
      step(4'd1, 4'd0, 32'd9, 32'd9);
      n = 0;
      while (Busy && n < 40) begin step(0, 0, 0, 0); n++; end
      chk("multu_busy_left", 64'(n), 64'd3);
      chk("multu_HI", 64'(HI), 64'hFFFF_FFFE);
      chk("multu_LO", 64'(LO), 64'h0000_0001);

      // divu 7/2, div -7/2, div 7/-2
      runOp(4'd4, 32'd7, 32'd2, n);
      chk("divu_busy_cycles", 64'(n), 64'd10);
      chk("divu_LO", 64'(LO), 64'd3);
      chk("divu_HI", 64'(HI), 64'd1);
      runOp(4'd3, 32'hFFFF_FFF9, 32'd2, n);
      chk("div_LO", 64'(LO), 64'hFFFF_FFFD);
      chk("div_HI", 64'(HI), 64'hFFFF_FFFF);
      runOp(4'd3, 32'd7, 32'hFFFF_FFFE, n);
      chk("div_negdivisor_LO", 64'(LO), 64'hFFFF_FFFD);
      chk("div_negdivisor_HI", 64'(HI), 64'd1);

      // divide by zero leaves preset HI/LO
      step(4'd7, 0, 32'h11, 0);
      step(4'd8, 0, 32'h22, 0);
      runOp(4'd3, 32'd5, 32'd0, n);
      chk("div0_busy_cycles", 64'(n), 64'd10);
      chk("div0_HI", 64'(HI), 64'h11);
      chk("div0_LO", 64'(LO), 64'h22);

      // mflo in D stalls until Busy falls, then reads the new LO
      step(4'd1, 0, 32'd6, 32'd7);
      n = 0;
      while (Busy && n < 40) begin step(4'd0, 4'd6, 0, 0); n++; end
      chk("stall_cycles", 64'(n), 64'd5);
      opE = 4'd6; opD = 4'd0; #1;
      chk("mflo_value", 64'(MDUOutE), 64'd42);
      chk("stall_released", 64'(StallMDU), 64'd0);
      step(4'd6, 0, 0, 0);
      step(4'd5, 4'd6, 0, 0);

      // reserved op is a no-op
      step(4'd12, 4'd3, 32'd1, 32'd1);
      chk("noop_busy", 64'(Busy), 64'd0);

      // madd
      step(4'd7, 0, 32'h0, 0);
      step(4'd8, 0, 32'hFFFF_FFFF, 0);
      runOp(4'd9, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
      chk("madd_HI", 64'(HI), 64'd1);
      chk("madd_LO", 64'(LO), 64'd0);
`else
      chk("madd_off_HI", 64'(HI), 64'd0);
      chk("madd_off_LO", 64'(LO), 64'hFFFF_FFFF);
`endif

      // reset during the 3rd busy cycle of a mult
      step(4'd7, 0, 32'h55, 0);
      step(4'd1, 0, 32'd5, 32'd5);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("pre_reset_busy", 64'(Busy), 64'd1);
      reset = 1'b1;
      #1;
      modelReset();
      chk("abort_Busy", 64'(Busy), 64'd0);
      chk("abort_HI", 64'(HI), 64'd0);
      chk("abort_LO", 64'(LO), 64'd0);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) step(0, 0, 0, 0);
      chk("no_late_HI", 64'(HI), 64'd0);
      chk("no_late_LO", 64'(LO), 64'd0);

      chkEn = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
